cfg_timeout_tracker: RTL and testbench



---
 rtl/cfg_timeout_pkg.sv | 25 ++
 rtl/cfg_timeout_queue.sv | 73 +++++++
 rtl/cfg_timeout_tracker.sv | 232 +++++++++++++++++++++++
 tb/tb_cfg_timeout_tracker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_timeout_pkg.sv
// Shared CSR map, synthetic-error constants and the tracked-entry record
// for the config-space timeout tracker.
package cfg_timeout_pkg;

  localparam int unsigned CSR_CTRL      = 0;
  localparam int unsigned CSR_TIMEOUT   = 1;
  localparam int unsigned CSR_STATUS    = 2;
  localparam int unsigned CSR_TO_COUNT  = 3;
  localparam int unsigned CSR_LAST_ADDR = 4;
  localparam int unsigned CSR_FF_COUNT  = 5;

  localparam int unsigned STATUS_MISMATCH_BIT = 18;

  localparam logic [31:0] ERR_READDATA = 32'hFFFF_FFFF;
  localparam logic [1:0]  ERR_RESP     = 2'b10;

  // Fields sized for the widest supported address/timer; the top zero-extends.
  typedef struct packed {
    logic        is_write;
    logic        is_local;
    logic [31:0] ts;
    logic [31:0] addr;
  } entry_t;

endpackage

// File: rtl/cfg_timeout_queue.sv
// In-order circular buffer of outstanding transactions with head/tail
// pointers and an occupancy count.
module cfg_timeout_queue
  import cfg_timeout_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  entry_t                     push_entry_i,
  input  logic                       pop_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CNT_W'(DEPTH));
    empty_o = (count_q == '0);
    head_o  = mem_q[head_q];
    count_o = count_q;

    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;

    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (do_push) begin
      mem_d[tail_q] = push_entry_i;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (do_pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cfg_timeout_tracker.sv
// Config-space pass-through that tracks outstanding requests, synthesises
// error completions on timeout, drops orphaned responses and fast-fails on link-down.
module cfg_timeout_tracker
  import cfg_timeout_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH        = 14,
  parameter int unsigned          DATA_WIDTH        = 32,
  parameter int unsigned          CSR_ADDR_WIDTH    = 8,
  parameter int unsigned          MAX_OUTSTANDING   = 4,
  parameter int unsigned          TIMER_WIDTH       = 24,
  parameter logic [TIMER_WIDTH-1:0] DEFAULT_TIMEOUT = 24'd1000000,
  parameter int unsigned          LTSSM_STATE_WIDTH = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         hps_address_i,
  input  logic [DATA_WIDTH-1:0]         hps_writedata_i,
  input  logic [DATA_WIDTH/8-1:0]       hps_byteenable_i,
  input  logic                          hps_read_i,
  input  logic                          hps_write_i,
  output logic                          hps_waitrequest_o,
  output logic                          hps_readdatavalid_o,
  output logic                          hps_writerespvalid_o,
  output logic [DATA_WIDTH-1:0]         hps_readdata_o,
  output logic [1:0]                    hps_resp_o,
  output logic [ADDR_WIDTH-1:0]         cs_address_o,
  output logic [DATA_WIDTH-1:0]         cs_writedata_o,
  output logic [DATA_WIDTH/8-1:0]       cs_byteenable_o,
  output logic                          cs_read_o,
  output logic                          cs_write_o,
  input  logic                          cs_waitrequest_i,
  input  logic                          cs_readdatavalid_i,
  input  logic                          cs_writerespvalid_i,
  input  logic [DATA_WIDTH-1:0]         cs_readdata_i,
  input  logic [1:0]                    cs_resp_i,
  input  logic [CSR_ADDR_WIDTH-1:0]     csr_address_i,
  input  logic                          csr_read_i,
  input  logic                          csr_write_i,
  input  logic [31:0]                   csr_writedata_i,
  output logic [31:0]                   csr_readdata_o,
  output logic                          csr_readdatavalid_o,
  input  logic                          hip_status_linkup,
  input  logic [LTSSM_STATE_WIDTH-1:0]  hip_status_ltssm_state
);

  localparam int unsigned CNT_W       = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned MAX_ORPHANS = 2 * MAX_OUTSTANDING - 1;

  entry_t                 q_head, push_entry;
  logic [CNT_W-1:0]       q_count;
  logic                   q_full, q_empty;

  logic [TIMER_WIDTH-1:0] now_q, now_d;
  logic                   en_q, en_d;
  logic                   ff_en_q, ff_en_d;
  logic [TIMER_WIDTH-1:0] timeout_q, timeout_d;
  logic                   mismatch_q, mismatch_d;
  logic [31:0]            to_count_q, to_count_d;
  logic [ADDR_WIDTH-1:0]  last_addr_q, last_addr_d;
  logic [31:0]            ff_count_q, ff_count_d;
  logic [7:0]             orphans_q, orphans_d;
  logic                   hps_rdv_q, hps_rdv_d;
  logic                   hps_wrv_q, hps_wrv_d;
  logic [DATA_WIDTH-1:0]  hps_rdata_q, hps_rdata_d;
  logic [1:0]             hps_resp_q, hps_resp_d;
  logic                   csr_rdv_q, csr_rdv_d;
  logic [31:0]            csr_rdata_q, csr_rdata_d;

  logic                   fast_fail, full, forward, accept;
  logic                   ip_resp, drop, fwd_resp, local_retire, timeout_hit, to_event, pop;
  logic [TIMER_WIDTH-1:0] elapsed;
  logic [31:0]            status;
  logic                   unused_bits;

  assign unused_bits = ^{csr_writedata_i, q_head.ts, q_head.addr, q_full};

  cfg_timeout_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (q_head),
    .count_o      (q_count),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  always_comb begin
    cs_address_o    = hps_address_i;
    cs_writedata_o  = hps_writedata_i;
    cs_byteenable_o = hps_byteenable_i;

    fast_fail = ff_en_q & ~hip_status_linkup;
    full      = (q_count == CNT_W'(MAX_OUTSTANDING)) | (orphans_q == 8'(MAX_ORPHANS));
    forward   = ~full & ~fast_fail;
    hps_waitrequest_o = fast_fail ? full : (cs_waitrequest_i | full);
    cs_read_o  = hps_read_i & forward;
    cs_write_o = hps_write_i & forward;
    accept     = (hps_read_i | hps_write_i) & ~hps_waitrequest_o;

    push_entry          = '0;
    push_entry.is_write = hps_write_i;
    push_entry.is_local = fast_fail;
    push_entry.ts       = 32'(now_q);
    push_entry.addr     = 32'(hps_address_i);

    // A forwarded IP response takes precedence over a same-cycle head timeout.
    elapsed      = now_q - q_head.ts[TIMER_WIDTH-1:0];
    ip_resp      = cs_readdatavalid_i | cs_writerespvalid_i;
    drop         = ip_resp & (orphans_q != '0);
    fwd_resp     = ip_resp & ~drop & ~q_empty & ~q_head.is_local;
    local_retire = ~q_empty & q_head.is_local;
    timeout_hit  = en_q & (timeout_q != '0) & ~q_empty & ~q_head.is_local &
                   (elapsed >= timeout_q);
    to_event     = timeout_hit & ~fwd_resp;
    pop          = fwd_resp | to_event | local_retire;

    now_d       = now_q + TIMER_WIDTH'(1);
    orphans_d   = orphans_q - 8'(drop) + 8'(to_event);
    last_addr_d = to_event ? q_head.addr[ADDR_WIDTH-1:0] : last_addr_q;

    hps_rdv_d   = 1'b0;
    hps_wrv_d   = 1'b0;
    hps_rdata_d = hps_rdata_q;
    hps_resp_d  = hps_resp_q;
    if (fwd_resp) begin
      hps_rdv_d   = cs_readdatavalid_i;
      hps_wrv_d   = cs_writerespvalid_i;
      hps_rdata_d = cs_readdata_i;
      hps_resp_d  = cs_resp_i;
    end else if (to_event || local_retire) begin
      hps_rdv_d   = ~q_head.is_write;
      hps_wrv_d   = q_head.is_write;
      hps_rdata_d = DATA_WIDTH'(ERR_READDATA);
      hps_resp_d  = ERR_RESP;
    end

    status = '0;
    status[7:0]   = 8'(q_count);
    status[15:8]  = orphans_q;
    status[16]    = hip_status_linkup;
    status[STATUS_MISMATCH_BIT] = mismatch_q;
    status[24 +: LTSSM_STATE_WIDTH] = hip_status_ltssm_state;

    en_d       = en_q;
    ff_en_d    = ff_en_q;
    timeout_d  = timeout_q;
    mismatch_d = mismatch_q;
    to_count_d = (to_event && to_count_q != '1) ? to_count_q + 32'd1 : to_count_q;
    ff_count_d = local_retire ? ff_count_q + 32'd1 : ff_count_q;

    // W1C is applied before the set so a same-cycle mismatch is never lost.
    if (csr_write_i) begin
      case (csr_address_i)
        CSR_ADDR_WIDTH'(CSR_CTRL): begin
          en_d    = csr_writedata_i[0];
          ff_en_d = csr_writedata_i[1];
        end
        CSR_ADDR_WIDTH'(CSR_TIMEOUT):  timeout_d  = csr_writedata_i[TIMER_WIDTH-1:0];
        CSR_ADDR_WIDTH'(CSR_STATUS):   if (csr_writedata_i[STATUS_MISMATCH_BIT]) mismatch_d = 1'b0;
        CSR_ADDR_WIDTH'(CSR_TO_COUNT): to_count_d = '0;
        CSR_ADDR_WIDTH'(CSR_FF_COUNT): ff_count_d = '0;
        default: ;
      endcase
    end
    if (ip_resp && !drop &&
        (q_empty || q_head.is_local || (q_head.is_write != cs_writerespvalid_i))) begin
      mismatch_d = 1'b1;
    end

    csr_rdv_d   = csr_read_i;
    csr_rdata_d = csr_rdata_q;
    if (csr_read_i) begin
      case (csr_address_i)
        CSR_ADDR_WIDTH'(CSR_CTRL):      csr_rdata_d = {30'd0, ff_en_q, en_q};
        CSR_ADDR_WIDTH'(CSR_TIMEOUT):   csr_rdata_d = 32'(timeout_q);
        CSR_ADDR_WIDTH'(CSR_STATUS):    csr_rdata_d = status;
        CSR_ADDR_WIDTH'(CSR_TO_COUNT):  csr_rdata_d = to_count_q;
        CSR_ADDR_WIDTH'(CSR_LAST_ADDR): csr_rdata_d = 32'(last_addr_q);
        CSR_ADDR_WIDTH'(CSR_FF_COUNT):  csr_rdata_d = ff_count_q;
        default:                        csr_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      now_q       <= '0;
      en_q        <= 1'b1;
      ff_en_q     <= 1'b0;
      timeout_q   <= DEFAULT_TIMEOUT;
      mismatch_q  <= 1'b0;
      to_count_q  <= '0;
      last_addr_q <= '0;
      ff_count_q  <= '0;
      orphans_q   <= '0;
      hps_rdv_q   <= 1'b0;
      hps_wrv_q   <= 1'b0;
      hps_rdata_q <= '0;
      hps_resp_q  <= '0;
      csr_rdv_q   <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      now_q       <= now_d;
      en_q        <= en_d;
      ff_en_q     <= ff_en_d;
      timeout_q   <= timeout_d;
      mismatch_q  <= mismatch_d;
      to_count_q  <= to_count_d;
      last_addr_q <= last_addr_d;
      ff_count_q  <= ff_count_d;
      orphans_q   <= orphans_d;
      hps_rdv_q   <= hps_rdv_d;
      hps_wrv_q   <= hps_wrv_d;
      hps_rdata_q <= hps_rdata_d;
      hps_resp_q  <= hps_resp_d;
      csr_rdv_q   <= csr_rdv_d;
      csr_rdata_q <= csr_rdata_d;
    end
  end

  assign hps_readdatavalid_o  = hps_rdv_q;
  assign hps_writerespvalid_o = hps_wrv_q;
  assign hps_readdata_o       = hps_rdata_q;
  assign hps_resp_o           = hps_resp_q;
  assign csr_readdatavalid_o  = csr_rdv_q;
  assign csr_readdata_o       = csr_rdata_q;

endmodule

// File: tb/tb_cfg_timeout_tracker.sv
// Directed bench for cfg_timeout_tracker: timeout, orphan drop, in-order
// pass-through, backpressure on full, fast-fail and the response/timeout race.
module tb_cfg_timeout_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [13:0] hps_address_i;
  logic [31:0] hps_writedata_i;
  logic [3:0]  hps_byteenable_i;
  logic        hps_read_i, hps_write_i;
  logic        hps_waitrequest_o, hps_readdatavalid_o, hps_writerespvalid_o;
  logic [31:0] hps_readdata_o;
  logic [1:0]  hps_resp_o;
  logic [13:0] cs_address_o;
  logic [31:0] cs_writedata_o;
  logic [3:0]  cs_byteenable_o;
  logic        cs_read_o, cs_write_o;
  logic        cs_waitrequest_i, cs_readdatavalid_i, cs_writerespvalid_i;
  logic [31:0] cs_readdata_i;
  logic [1:0]  cs_resp_i;
  logic [7:0]  csr_address_i;
  logic        csr_read_i, csr_write_i;
  logic [31:0] csr_writedata_i;
  logic [31:0] csr_readdata_o;
  logic        csr_readdatavalid_o;
  logic        hip_status_linkup;
  logic [5:0]  hip_status_ltssm_state;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned n;

  always #5 clk_i = ~clk_i;

  cfg_timeout_tracker #(
    .ADDR_WIDTH        (14),
    .DATA_WIDTH        (32),
    .CSR_ADDR_WIDTH    (8),
    .MAX_OUTSTANDING   (4),
    .TIMER_WIDTH       (24),
    .DEFAULT_TIMEOUT   (24'd1000000),
    .LTSSM_STATE_WIDTH (6)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .hps_address_i          (hps_address_i),
    .hps_writedata_i        (hps_writedata_i),
    .hps_byteenable_i       (hps_byteenable_i),
    .hps_read_i             (hps_read_i),
    .hps_write_i            (hps_write_i),
    .hps_waitrequest_o      (hps_waitrequest_o),
    .hps_readdatavalid_o    (hps_readdatavalid_o),
    .hps_writerespvalid_o   (hps_writerespvalid_o),
    .hps_readdata_o         (hps_readdata_o),
    .hps_resp_o             (hps_resp_o),
    .cs_address_o           (cs_address_o),
    .cs_writedata_o         (cs_writedata_o),
    .cs_byteenable_o        (cs_byteenable_o),
    .cs_read_o              (cs_read_o),
    .cs_write_o             (cs_write_o),
    .cs_waitrequest_i       (cs_waitrequest_i),
    .cs_readdatavalid_i     (cs_readdatavalid_i),
    .cs_writerespvalid_i    (cs_writerespvalid_i),
    .cs_readdata_i          (cs_readdata_i),
    .cs_resp_i              (cs_resp_i),
    .csr_address_i          (csr_address_i),
    .csr_read_i             (csr_read_i),
    .csr_write_i            (csr_write_i),
    .csr_writedata_i        (csr_writedata_i),
    .csr_readdata_o         (csr_readdata_o),
    .csr_readdatavalid_o    (csr_readdatavalid_o),
    .hip_status_linkup      (hip_status_linkup),
    .hip_status_ltssm_state (hip_status_ltssm_state)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    csr_address_i   = a;
    csr_writedata_i = d;
    csr_write_i     = 1'b1;
    tick();
    csr_write_i     = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    csr_address_i = a;
    csr_read_i    = 1'b1;
    tick();
    csr_read_i    = 1'b0;
    check({tag, "_valid"}, 32'(csr_readdatavalid_o), 32'd1);
    check(tag, csr_readdata_o, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    hps_address_i = '0; hps_writedata_i = '0; hps_byteenable_i = 4'hF;
    hps_read_i = 1'b0; hps_write_i = 1'b0;
    cs_waitrequest_i = 1'b0; cs_readdatavalid_i = 1'b0; cs_writerespvalid_i = 1'b0;
    cs_readdata_i = '0; cs_resp_i = '0;
    csr_address_i = '0; csr_read_i = 1'b0; csr_write_i = 1'b0; csr_writedata_i = '0;
    hip_status_linkup = 1'b1; hip_status_ltssm_state = 6'h11;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    check("rst_rdv",   32'(hps_readdatavalid_o),  32'd0);
    check("rst_wrv",   32'(hps_writerespvalid_o), 32'd0);
    check("rst_rdata", hps_readdata_o,            32'd0);
    check("rst_resp",  32'(hps_resp_o),           32'd0);
    check("rst_csrv",  32'(csr_readdatavalid_o),  32'd0);
    csr_rd("rst_ctrl",    8'd0, 32'h0000_0001);
    csr_rd("rst_timeout", 8'd1, 32'd1000000);
    csr_rd("rst_status",  8'd2, 32'h1101_0000);
    csr_rd("rst_unmapped", 8'd9, 32'd0);

    // Timeout: T=100, read with no IP response
    csr_wr(8'd1, 32'd100);
    csr_rd("timeout_rb", 8'd1, 32'd100);
    hps_address_i = 14'h0155;
    hps_read_i    = 1'b1;
    #1;
    check("to_cs_read", 32'(cs_read_o),         32'd1);
    check("to_cs_addr", 32'(cs_address_o),      32'h0155);
    check("to_wait",    32'(hps_waitrequest_o), 32'd0);
    tick();
    hps_read_i = 1'b0;
    n = 0;
    while (!hps_readdatavalid_o && n < 200) begin
      tick();
      n++;
    end
    check("to_latency", n,                 32'd100);
    check("to_rdata",   hps_readdata_o,    32'hFFFF_FFFF);
    check("to_resp",    32'(hps_resp_o),   32'h2);
    tick();
    check("to_rdv_clr", 32'(hps_readdatavalid_o), 32'd0);
    csr_rd("to_count",  8'd3, 32'd1);
    csr_rd("to_addr",   8'd4, 32'h0155);
    csr_rd("to_status", 8'd2, 32'h1101_0100);

    // Late IP response is dropped as an orphan
    cs_readdatavalid_i = 1'b1;
    cs_readdata_i      = 32'h0000_DEAD;
    tick();
    cs_readdatavalid_i = 1'b0;
    check("orph_drop", 32'(hps_readdatavalid_o), 32'd0);
    csr_rd("orph_status", 8'd2, 32'h1101_0000);

    // Next read gets its real data
    hps_address_i = 14'h0222;
    hps_read_i    = 1'b1;
    tick();
    hps_read_i = 1'b0;
    tick();
    tick();
    cs_readdatavalid_i = 1'b1;
    cs_readdata_i      = 32'h1234_5678;
    cs_resp_i          = 2'b00;
    tick();
    cs_readdatavalid_i = 1'b0;
    check("real_rdv",   32'(hps_readdatavalid_o), 32'd1);
    check("real_rdata", hps_readdata_o,           32'h1234_5678);
    check("real_resp",  32'(hps_resp_o),          32'd0);
    tick();
    check("real_rdv_clr", 32'(hps_readdatavalid_o), 32'd0);

    // Four back-to-back reads answered at latency 5; fifth held off while full
    for (int k = 0; k < 12; k++) begin
      hps_read_i         = (k <= 6);
      hps_address_i      = 14'h0100 + 14'(k);
      cs_readdatavalid_i = ((k >= 5) && (k <= 8)) || (k == 10);
      cs_readdata_i      = 32'hA000_0000 + 32'(k);
      #1;
      if (k <= 6) begin
        check("b2b_wait",    32'(hps_waitrequest_o), (k == 4 || k == 5) ? 32'd1 : 32'd0);
        check("b2b_cs_read", 32'(cs_read_o),         (k == 4 || k == 5) ? 32'd0 : 32'd1);
      end
      check("b2b_rdv", 32'(hps_readdatavalid_o),
            (((k >= 6) && (k <= 9)) || (k == 11)) ? 32'd1 : 32'd0);
      if (((k >= 6) && (k <= 9)) || (k == 11)) begin
        check("b2b_rdata", hps_readdata_o, 32'hA000_0000 + 32'(k - 1));
      end
      tick();
    end
    hps_read_i         = 1'b0;
    cs_readdatavalid_i = 1'b0;
    csr_rd("b2b_to_count", 8'd3, 32'd1);
    csr_rd("b2b_status",   8'd2, 32'h1101_0000);

    // Fast-fail write while the link is down
    csr_wr(8'd0, 32'd3);
    hip_status_linkup = 1'b0;
    hps_address_i     = 14'h0333;
    hps_write_i       = 1'b1;
    #1;
    check("ff_cs_write", 32'(cs_write_o),        32'd0);
    check("ff_wait",     32'(hps_waitrequest_o), 32'd0);
    tick();
    hps_write_i = 1'b0;
    check("ff_wrv_early", 32'(hps_writerespvalid_o), 32'd0);
    tick();
    check("ff_wrv",  32'(hps_writerespvalid_o), 32'd1);
    check("ff_rdv",  32'(hps_readdatavalid_o),  32'd0);
    check("ff_resp", 32'(hps_resp_o),           32'h2);
    tick();
    check("ff_wrv_clr", 32'(hps_writerespvalid_o), 32'd0);
    csr_rd("ff_count", 8'd5, 32'd1);
    hip_status_linkup = 1'b1;
    csr_wr(8'd0, 32'd1);
    csr_wr(8'd5, 32'd0);
    csr_rd("ff_count_clr", 8'd5, 32'd0);

    // Stray response with nothing outstanding sets sticky mismatch
    cs_writerespvalid_i = 1'b1;
    tick();
    cs_writerespvalid_i = 1'b0;
    check("mm_wrv", 32'(hps_writerespvalid_o), 32'd0);
    csr_rd("mm_status", 8'd2, 32'h1105_0000);
    csr_wr(8'd2, 32'h0004_0000);
    csr_rd("mm_w1c", 8'd2, 32'h1101_0000);

    // IP response in the same cycle the head reaches elapsed==T
    csr_wr(8'd3, 32'd0);
    csr_rd("race_count_clr", 8'd3, 32'd0);
    csr_wr(8'd1, 32'd20);
    hps_address_i = 14'h0444;
    hps_read_i    = 1'b1;
    tick();
    hps_read_i = 1'b0;
    repeat (19) tick();
    check("race_pre_rdv", 32'(hps_readdatavalid_o), 32'd0);
    cs_readdatavalid_i = 1'b1;
    cs_readdata_i      = 32'hCAFE_F00D;
    cs_resp_i          = 2'b00;
    tick();
    cs_readdatavalid_i = 1'b0;
    check("race_rdv",   32'(hps_readdatavalid_o), 32'd1);
    check("race_rdata", hps_readdata_o,           32'hCAFE_F00D);
    check("race_resp",  32'(hps_resp_o),          32'd0);
    tick();
    check("race_rdv_clr", 32'(hps_readdatavalid_o), 32'd0);
    csr_rd("race_to_count", 8'd3, 32'd0);
    csr_rd("race_status",   8'd2, 32'h1101_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
